// File: rtl/sonuc_bcd_cevirici.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for the
// calculator result; invalid or overflowed results skip conversion and flag an error.
module sonuc_bcd_cevirici #(
  parameter int GENISLIK = 64,
  parameter int BASAMAK  = 20,
  parameter int ISARETLI = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GENISLIK-1:0]    sonuc,
  input  logic                   hazir,
  input  logic                   gecerli,
  input  logic                   tasma,
  output logic [4*BASAMAK-1:0]   bcd,
  output logic                   negatif,
  output logic                   bcd_gecerli,
  output logic                   hata,
  output logic                   mesgul,
  output logic                   bcd_hazir
);

  localparam int SAYAC_W = $clog2(GENISLIK);
  localparam int BCD_W   = 4 * BASAMAK;

  typedef enum logic [1:0] {BOSTA, CEVIR, BITTI} durum_t;

  durum_t                durum, durum_sonraki;
  logic                  hazir_onceki;
  logic                  baslat;
  logic                  sonuc_negatif;
  logic [GENISLIK-1:0]   buyukluk;
  logic [SAYAC_W-1:0]    sayac;
  logic [GENISLIK-1:0]   kaydirma;
  logic [BCD_W-1:0]      birikim;
  logic [BCD_W-1:0]      birikim_duz;
  logic                  isaret_r;
  logic                  hata_r;

  assign baslat        = hazir && !hazir_onceki && (durum == BOSTA);
  assign sonuc_negatif = (ISARETLI != 0) && sonuc[GENISLIK-1];
  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign buyukluk      = sonuc_negatif ? -sonuc : sonuc;
  assign mesgul        = (durum != BOSTA);

  always_comb begin
    birikim_duz = birikim;
    for (int unsigned i = 0; i < BASAMAK; i++) begin
      if (birikim[4*i +: 4] >= 4'd5)
        birikim_duz[4*i +: 4] = birikim[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOSTA: if (baslat) durum_sonraki = (!gecerli || tasma) ? BITTI : CEVIR;
      CEVIR: if (sayac == SAYAC_W'(GENISLIK - 1)) durum_sonraki = BITTI;
      BITTI: durum_sonraki = BOSTA;
      default: durum_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) durum <= BOSTA;
    else     durum <= durum_sonraki;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hazir_onceki <= 1'b1;
      sayac        <= '0;
      kaydirma     <= '0;
      birikim      <= '0;
      isaret_r     <= 1'b0;
      hata_r       <= 1'b0;
      bcd          <= '0;
      negatif      <= 1'b0;
      bcd_gecerli  <= 1'b0;
      hata         <= 1'b0;
      bcd_hazir    <= 1'b0;
    end else begin
      hazir_onceki <= hazir;
      bcd_hazir    <= 1'b0;
      case (durum)
        BOSTA: begin
          if (baslat) begin
            hata_r   <= !gecerli || tasma;
            isaret_r <= sonuc_negatif;
            kaydirma <= buyukluk;
            birikim  <= '0;
            sayac    <= '0;
          end
        end
        CEVIR: begin
          birikim  <= {birikim_duz[BCD_W-2:0], kaydirma[GENISLIK-1]};
          kaydirma <= {kaydirma[GENISLIK-2:0], 1'b0};
          sayac    <= sayac + SAYAC_W'(1);
        end
        BITTI: begin
          bcd_hazir <= 1'b1;
          if (hata_r) begin
            bcd         <= '0;
            negatif     <= 1'b0;
            bcd_gecerli <= 1'b0;
            hata        <= 1'b1;
          end else begin
            bcd         <= birikim;
            negatif     <= isaret_r;
            bcd_gecerli <= 1'b1;
            hata        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sonuc_bcd_cevirici.sv
// Bench for sonuc_bcd_cevirici: signed and unsigned instances share stimulus and are
// compared against a decimal reference built with plain division.
module tb_sonuc_bcd_cevirici;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] sonuc;
  logic        hazir, gecerli, tasma;

  logic [79:0] bcd_s, bcd_u;
  logic        negatif_s, negatif_u, bcd_gecerli_s, bcd_gecerli_u;
  logic        hata_s, hata_u, mesgul_s, mesgul_u, bcd_hazir_s, bcd_hazir_u;

  int n_chk  = 0;
  int n_fail = 0;
  logic [79:0] prev_s = '0;
  logic [79:0] prev_u = '0;

  always #5 clk = ~clk;

  sonuc_bcd_cevirici #(.GENISLIK(64), .BASAMAK(20), .ISARETLI(1)) dut_s (
    .clk(clk), .rst(rst), .sonuc(sonuc), .hazir(hazir), .gecerli(gecerli), .tasma(tasma),
    .bcd(bcd_s), .negatif(negatif_s), .bcd_gecerli(bcd_gecerli_s), .hata(hata_s),
    .mesgul(mesgul_s), .bcd_hazir(bcd_hazir_s));

  sonuc_bcd_cevirici #(.GENISLIK(64), .BASAMAK(20), .ISARETLI(0)) dut_u (
    .clk(clk), .rst(rst), .sonuc(sonuc), .hazir(hazir), .gecerli(gecerli), .tasma(tasma),
    .bcd(bcd_u), .negatif(negatif_u), .bcd_gecerli(bcd_gecerli_u), .hata(hata_u),
    .mesgul(mesgul_u), .bcd_hazir(bcd_hazir_u));

  function automatic logic [79:0] ref_bcd(input logic [63:0] v);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 20; i++) begin
      r[4*i +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bcd_s"}, bcd_s, '0);
    chk({tag, "_bcd_u"}, bcd_u, '0);
    chk1({tag, "_negatif"}, negatif_s | negatif_u, 1'b0);
    chk1({tag, "_bcd_gecerli"}, bcd_gecerli_s | bcd_gecerli_u, 1'b0);
    chk1({tag, "_hata"}, hata_s | hata_u, 1'b0);
    chk1({tag, "_mesgul"}, mesgul_s | mesgul_u, 1'b0);
    chk1({tag, "_bcd_hazir"}, bcd_hazir_s | bcd_hazir_u, 1'b0);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      if (bcd_hazir_s) p++;
    end
  endtask

  // Waits (bounded) for the completion pulse; cnt = edges since the capture edge.
  task automatic wait_pulse(inout int cnt, output logic held);
    held = 1'b1;
    while (!bcd_hazir_s && cnt < 300) begin
      if (bcd_s !== prev_s || bcd_u !== prev_u) held = 1'b0;
      @(posedge clk); cnt++; @(negedge clk);
    end
  endtask

  task automatic do_conv(input logic [63:0] s, input logic g, input logic t);
    logic [79:0] eb_s, eb_u;
    logic ev, en_s, held;
    int cnt, lat;
    ev   = g && !t;
    eb_s = ev ? ref_bcd(s[63] ? -s : s) : '0;
    eb_u = ev ? ref_bcd(s) : '0;
    en_s = ev && s[63];
    lat  = ev ? 65 : 1;
    @(negedge clk); hazir = 1'b0; sonuc = s; gecerli = g; tasma = t;
    @(negedge clk); hazir = 1'b1;
    @(posedge clk); @(negedge clk);
    chk1("mesgul_after_capture", mesgul_s & mesgul_u, 1'b1);
    cnt = 0;
    wait_pulse(cnt, held);
    chk("latency", 80'(cnt), 80'(lat));
    chk1("pulse_u", bcd_hazir_u, 1'b1);
    chk("bcd_s", bcd_s, eb_s);
    chk("bcd_u", bcd_u, eb_u);
    chk1("negatif_s", negatif_s, en_s);
    chk1("negatif_u", negatif_u, 1'b0);
    chk1("bcd_gecerli", bcd_gecerli_s & bcd_gecerli_u, ev);
    chk1("hata", hata_s | hata_u, !ev);
    chk1("mesgul_at_done", mesgul_s | mesgul_u, 1'b0);
    chk1("bcd_held_while_busy", held, 1'b1);
    @(posedge clk); @(negedge clk);
    chk1("pulse_one_cycle", bcd_hazir_s | bcd_hazir_u, 1'b0);
    chk("bcd_hold_after", bcd_s, eb_s);
    prev_s = eb_s;
    prev_u = eb_u;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p, cnt;
    logic held;
    logic [63:0] s;

    // Reset with hazir already high: no conversion may start after release.
    rst = 1'b1; hazir = 1'b1; sonuc = 64'd42; gecerli = 1'b1; tasma = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    count_pulses(20, p);
    chk("hazir_high_after_reset_pulses", 80'(p), 80'd0);
    chk1("hazir_high_after_reset_idle", mesgul_s | mesgul_u, 1'b0);

    do_conv(64'd12345, 1'b1, 1'b0);
    do_conv(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_conv(64'h8000_0000_0000_0000, 1'b1, 1'b0);
    do_conv(64'd0, 1'b1, 1'b0);
    do_conv(64'd77, 1'b0, 1'b0);
    do_conv(64'd77, 1'b1, 1'b1);
    do_conv(64'd1, 1'b1, 1'b0);
    do_conv(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      s = {$urandom, $urandom};
      if (i % 4 == 1) s = 64'($urandom_range(0, 100000));
      if (i % 4 == 2) s = -64'($urandom_range(0, 100000));
      do_conv(s, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
    end

    // A second hazir edge 30 clocks into a conversion is dropped.
    @(negedge clk); hazir = 1'b0; sonuc = 64'd999; gecerli = 1'b1; tasma = 1'b0;
    @(negedge clk); hazir = 1'b1;
    @(posedge clk);
    cnt = 0;
    repeat (30) begin @(posedge clk); cnt++; end
    @(negedge clk); hazir = 1'b0; sonuc = 64'd5;
    @(posedge clk); cnt++;
    @(negedge clk); hazir = 1'b1;
    wait_pulse(cnt, held);
    chk("drop_latency", 80'(cnt), 80'd65);
    chk("drop_bcd", bcd_s, ref_bcd(64'd999));
    chk1("drop_held", held, 1'b1);
    prev_s = ref_bcd(64'd999);
    prev_u = prev_s;
    count_pulses(100, p);
    chk("drop_no_second_pulse", 80'(p), 80'd0);

    // hazir held high for 200 clocks gives exactly one conversion.
    s = {$urandom, $urandom};
    @(negedge clk); hazir = 1'b0; sonuc = s;
    @(negedge clk); hazir = 1'b1;
    count_pulses(200, p);
    chk("held_high_pulses", 80'(p), 80'd1);
    chk("held_high_bcd_u", bcd_u, ref_bcd(s));
    prev_s = bcd_s;
    prev_u = ref_bcd(s);

    // Reset at iteration 40 discards the conversion.
    @(negedge clk); hazir = 1'b0; sonuc = 64'd123456789;
    @(negedge clk); hazir = 1'b1;
    @(posedge clk);
    repeat (40) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk_reset_vals("midreset");
    count_pulses(100, p);
    chk("midreset_no_pulse", 80'(p), 80'd0);
    chk1("midreset_idle", mesgul_s | mesgul_u, 1'b0);
    prev_s = '0;
    prev_u = '0;
    do_conv(64'd12345, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
